// File: rtl/full_subtractor_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : full_subtractor_pkg
// Brief    : Shared width default and the one-bit borrow/difference slice.
// Revision : 1.0
// ============================================================================
package full_subtractor_pkg;

    localparam int FS_WIDTH_DEFAULT = 1;
    localparam int FS_WIDTH_MAX     = 64;

    typedef struct packed {
        logic bo;
        logic d;
    } fs_slice_t;

    function automatic fs_slice_t fs_slice(input logic a, input logic b, input logic bin);
        fs_slice_t r;
        r.d  = a ^ b ^ bin;
        r.bo = (~a & b) | (~(a ^ b) & bin);
        return r;
    endfunction

endpackage : full_subtractor_pkg

`default_nettype wire

// File: rtl/full_subtractor_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : full_subtractor_if
// Brief    : Operand/result bundle; master drives operands, slave returns results.
// Revision : 1.0
// ============================================================================
interface full_subtractor_if
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH_DEFAULT
);

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  diff, bout, ovf, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output diff, bout, ovf, out_valid
    );

endinterface : full_subtractor_if

`default_nettype wire

// File: rtl/full_sub_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : full_sub_cell
// Brief    : One stage of the ripple-borrow chain.
// Revision : 1.0
// ============================================================================
module full_sub_cell
    import full_subtractor_pkg::*;
(
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic bin_i,
    output logic      d_o,
    output logic      bo_o
);

    fs_slice_t w_slice;

    assign w_slice = fs_slice(a_i, b_i, bin_i);
    assign d_o     = w_slice.d;
    assign bo_o    = w_slice.bo;

endmodule : full_sub_cell

`default_nettype wire

// File: rtl/full_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : full_subtractor
// Brief    : WIDTH-bit ripple-borrow subtractor with one output register stage.
// Revision : 1.0
// ============================================================================
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = FS_WIDTH_DEFAULT
)(
    input  wire logic         clk,
    input  wire logic         rst_n,
    full_subtractor_if.slave  bus
);

    logic [WIDTH:0]   w_br;
    logic [WIDTH-1:0] w_d;

    logic [WIDTH-1:0] diff_d,  diff_q;
    logic             bout_d,  bout_q;
    logic             ovf_d,   ovf_q;
    logic             valid_d, valid_q;

    assign w_br[0] = bus.cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_sub_cell u_cell (
                .a_i   (bus.a[gi]),
                .b_i   (bus.b[gi]),
                .bin_i (w_br[gi]),
                .d_o   (w_d[gi]),
                .bo_o  (w_br[gi+1])
            );
        end
    endgenerate

    // Result registers hold their last value while no new operands arrive.
    always_comb begin
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            diff_d = w_d;
            bout_d = w_br[WIDTH];
            ovf_d  = w_br[WIDTH] ^ w_br[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign bus.diff      = diff_q;
    assign bus.bout      = bout_q;
    assign bus.ovf       = ovf_q;
    assign bus.out_valid = valid_q;

endmodule : full_subtractor

`default_nettype wire

// File: tb/tb_full_subtractor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_full_subtractor
// Brief    : Scoreboard bench for 1-bit and 8-bit subtractor instances.
// Revision : 1.0
// ============================================================================
module tb_full_subtractor;

    typedef struct {
        logic [63:0] d;
        logic        bo;
        logic        ov;
        int          due;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;

    exp_t q1[$];
    exp_t q8[$];
    exp_t h1, h8, e1, e8;

    logic [1:0] tab1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};

    full_subtractor_if #(.WIDTH(1)) if1 ();
    full_subtractor_if #(.WIDTH(8)) if8 ();

    full_subtractor #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    full_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t ref_sub(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic cin);
        exp_t   r;
        longint sa, sb, sr, lim;
        logic [63:0] mask;
        mask  = (64'd1 << w) - 64'd1;
        r.d   = (a - b - 64'(cin)) & mask;
        r.bo  = (a < (b + 64'(cin)));
        sa    = a[w-1] ? (longint'(a) - (longint'(1) << w)) : longint'(a);
        sb    = b[w-1] ? (longint'(b) - (longint'(1) << w)) : longint'(b);
        sr    = sa - sb - longint'(cin);
        lim   = longint'(1) << (w - 1);
        r.ov  = (sr < -lim) || (sr >= lim);
        r.due = 0;
        return r;
    endfunction

    task automatic send1(input logic a, input logic b, input logic cin, input exp_t e);
        e.due       = cyc + 1;
        if1.a       = a;
        if1.b       = b;
        if1.cin     = cin;
        if1.in_valid = 1'b1;
        q1.push_back(e);
        @(posedge clk); #1;
        if1.in_valid = 1'b0;
    endtask

    task automatic send8x(input logic [7:0] a, input logic [7:0] b, input logic cin, input exp_t e);
        e.due        = cyc + 1;
        if8.a        = a;
        if8.b        = b;
        if8.cin      = cin;
        if8.in_valid = 1'b1;
        q8.push_back(e);
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic cin);
        send8x(a, b, cin, ref_sub(8, 64'(a), 64'(b), cin));
    endtask

    task automatic idle(input int n);
        if1.in_valid = 1'b0;
        if8.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_zero(input string tag);
        cmp({tag, " w1 diff"},      64'(if1.diff),      64'd0);
        cmp({tag, " w1 bout"},      64'(if1.bout),      64'd0);
        cmp({tag, " w1 ovf"},       64'(if1.ovf),       64'd0);
        cmp({tag, " w1 out_valid"}, 64'(if1.out_valid), 64'd0);
        cmp({tag, " w8 diff"},      64'(if8.diff),      64'd0);
        cmp({tag, " w8 bout"},      64'(if8.bout),      64'd0);
        cmp({tag, " w8 ovf"},       64'(if8.ovf),       64'd0);
        cmp({tag, " w8 out_valid"}, 64'(if8.out_valid), 64'd0);
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.d = 64'd0; z.bo = 1'b0; z.ov = 1'b0; z.due = 0;
        return z;
    endfunction

    // Monitors: pop on every out_valid, otherwise confirm outputs are held.
    always @(negedge clk) begin
        if (rst_n) begin
            if (if1.out_valid) begin
                if (q1.size() == 0) begin
                    cmp("w1 spurious out_valid", 64'(if1.out_valid), 64'd0);
                end else begin
                    e1 = q1.pop_front();
                    cmp("w1 latency", 64'(cyc), 64'(e1.due));
                    cmp("w1 diff", 64'(if1.diff), e1.d);
                    cmp("w1 bout", 64'(if1.bout), 64'(e1.bo));
                    cmp("w1 ovf",  64'(if1.ovf),  64'(e1.ov));
                    h1 = e1;
                end
            end else begin
                if (q1.size() != 0 && q1[0].due <= cyc) begin
                    cmp("w1 missing out_valid", 64'(if1.out_valid), 64'd1);
                    void'(q1.pop_front());
                end
                cmp("w1 held diff", 64'(if1.diff), h1.d);
                cmp("w1 held bout", 64'(if1.bout), 64'(h1.bo));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (if8.out_valid) begin
                if (q8.size() == 0) begin
                    cmp("w8 spurious out_valid", 64'(if8.out_valid), 64'd0);
                end else begin
                    e8 = q8.pop_front();
                    cmp("w8 latency", 64'(cyc), 64'(e8.due));
                    cmp("w8 diff", 64'(if8.diff), e8.d);
                    cmp("w8 bout", 64'(if8.bout), 64'(e8.bo));
                    cmp("w8 ovf",  64'(if8.ovf),  64'(e8.ov));
                    h8 = e8;
                end
            end else begin
                if (q8.size() != 0 && q8[0].due <= cyc) begin
                    cmp("w8 missing out_valid", 64'(if8.out_valid), 64'd1);
                    void'(q8.pop_front());
                end
                cmp("w8 held diff", 64'(if8.diff), h8.d);
                cmp("w8 held bout", 64'(if8.bout), 64'(h8.bo));
                cmp("w8 held ovf",  64'(if8.ovf),  64'(h8.ov));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [2:0] v;
        n_tests = 0;
        n_fail  = 0;
        h1 = zero_exp();
        h8 = zero_exp();
        rst_n = 1'b0;
        if1.in_valid = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        idle(1);

        // 1-bit exhaustive against the truth table
        for (int i = 0; i < 8; i++) begin
            v   = 3'(i);
            e   = ref_sub(1, 64'(v[2]), 64'(v[1]), v[0]);
            e.d  = 64'(tab1[i][1]);
            e.bo = tab1[i][0];
            send1(v[2], v[1], v[0], e);
        end
        idle(3);

        // 8-bit boundaries
        e = zero_exp(); e.bo = 1'b1;
        send8x(8'h00, 8'hFF, 1'b1, e);
        e = zero_exp(); e.d = 64'h7F; e.ov = 1'b1;
        send8x(8'h80, 8'h01, 1'b0, e);
        e = zero_exp();
        send8x(8'h5A, 8'h5A, 1'b0, e);
        idle(3);

        // Four back-to-back distinct operand sets
        for (int i = 0; i < 4; i++)
            send8(8'(8'h11 * (i + 1) + $urandom_range(0, 15)), 8'($urandom), 1'($urandom));
        idle(3);

        // Random traffic with gaps on both instances
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) send8(8'($urandom), 8'($urandom), 1'($urandom));
            else idle(1);
        end
        for (int i = 0; i < 30; i++) begin
            v = 3'($urandom);
            if ($urandom_range(0, 2) != 0) send1(v[2], v[1], v[0], ref_sub(1, 64'(v[2]), 64'(v[1]), v[0]));
            else idle(1);
        end
        idle(2);

        // Reset between edges while a result is showing
        send8(8'h3C, 8'hC3, 1'b1);
        #1;
        cmp("pre-reset out_valid", 64'(if8.out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        q8.delete();
        q1.delete();
        h1 = zero_exp();
        h8 = zero_exp();
        if8.a = 8'hAA; if8.b = 8'h01; if8.in_valid = 1'b1;
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle(3);

        // First edge after release with in_valid must yield a result
        rst_n = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
        send8(8'h01, 8'h02, 1'b0);
        idle(3);

        cmp("w1 scoreboard drained", 64'(q1.size()), 64'd0);
        cmp("w8 scoreboard drained", 64'(q8.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_full_subtractor

`default_nettype wire

// File: doc/full_subtractor.md
FULL_SUBTRACTOR -- requirements
Module: full_subtractor

Interface
REQ-001 Parameter: WIDTH, default 1; operand width in bits, legal range 1..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  qualifies a, b, cin on the current clk edge.
REQ-005 Port: a  input  WIDTH  minuend, unsigned.
REQ-006 Port: b  input  WIDTH  subtrahend, unsigned.
REQ-007 Port: cin  input  1  borrow-in.
REQ-008 Port: diff  output  WIDTH  registered difference.
REQ-009 Port: bout  output  1  registered borrow-out.
REQ-010 Port: ovf  output  1  registered signed (two's-complement) overflow flag.
REQ-011 Port: out_valid  output  1  registered; high for the cycle in which diff/bout/ovf hold a new result.

Function
REQ-012 Per bit i: d[i] = a[i] ^ b[i] ^ br[i]; br[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]); br[0] = cin; ripple-borrow chain.
REQ-013 Result: diff = (a - b - cin) mod 2^WIDTH; bout = br[WIDTH] = 1 exactly when a < b + cin (unsigned).
REQ-014 ovf = br[WIDTH] ^ br[WIDTH-1], i.e. a, b signed and the result sign is wrong; for WIDTH=1, ovf = bout ^ cin.
REQ-015 Latency: exactly 1 clk cycle; inputs sampled on edge N with in_valid=1 give diff/bout/ovf and out_valid=1 after edge N.
REQ-016 in_valid=0 on an edge: diff/bout/ovf hold their previous values; out_valid=0.
REQ-017 Back-to-back: in_valid=1 on consecutive edges gives a new result every cycle, no bubbles, no stall input.
REQ-018 Boundary: a=0, b=all-ones, cin=1 gives diff=0, bout=1 (borrow wrap); a=b, cin=0 gives diff=0, bout=0.
REQ-019 No X propagation from held outputs; outputs depend only on registered state.

Reset
REQ-020 rst_n=0 immediately forces diff=0, bout=0, ovf=0, out_valid=0, regardless of clk.
REQ-021 Release of rst_n is synchronised by the implementation's sampling on clk; the first edge with rst_n=1 and in_valid=1 produces a valid result.
REQ-022 Reset asserted mid-stream discards any pending result; no out_valid pulse follows reset release without a new in_valid.

Structure
REQ-023 Shared package full_subtractor_pkg holds the WIDTH default and the borrow/difference bit-slice function.
REQ-024 One sub-module full_sub_cell (1-bit a, b, bin to d, bo), instantiated WIDTH times via generate to form the chain.
REQ-025 Top level holds the input-to-output register stage and the ovf derivation only; no other state.

Verification
REQ-026 WIDTH=1, exhaustive {a,b,cin}=0..7 with in_valid=1 gives (diff,bout) = 00,11,11,01,10,00,00,11 one cycle later.
REQ-027 WIDTH=8: a=0x00, b=0xFF, cin=1 gives diff=0x00, bout=1; a=0x80, b=0x01, cin=0 gives diff=0x7F, bout=0, ovf=1.
REQ-028 WIDTH=8: in_valid high 4 consecutive cycles with distinct operands gives 4 consecutive out_valid pulses with matching results in order.
REQ-029 in_valid=0 for 3 cycles after a result: diff/bout unchanged, out_valid=0.
REQ-030 rst_n pulled low between clk edges with out_valid=1: all outputs become 0 immediately; after release, out_valid stays 0 until the next in_valid.
